// File: rtl/seq_gen_1011.sv
// Serial pattern generator: emits PATTERN MSB first, reps times per frame,
// with GAP_LEN idle cycles between repetitions and a ready/valid handshake.
module seq_gen_1011 #(
  parameter logic [3:0]  PATTERN = 4'b1011,
  parameter int unsigned GAP_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] reps,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, FIN} state_e;

  // Gap counter is loaded with the index of the last gap cycle.
  localparam logic [2:0] GAP_LAST = (GAP_LEN > 0) ? 3'(GAP_LEN - 1) : 3'd0;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] gap_q, gap_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd3;
      cnt_q   <= 4'd0;
      gap_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Outputs decode registered state only; out_ready steers next state alone.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    out_bit   = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = reps;
          idx_d   = 2'd3;
          state_d = (reps == 4'd0) ? FIN : SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_bit   = PATTERN[idx_q];
        if (out_ready) begin
          if (idx_q != 2'd0) begin
            idx_d = idx_q - 2'd1;
          end else begin
            cnt_d = cnt_q - 4'd1;
            idx_d = 2'd3;
            if (cnt_q == 4'd1) begin
              state_d = FIN;
            end else if (GAP_LEN > 0) begin
              state_d = GAP;
              gap_d   = GAP_LAST;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == 3'd0) begin
          state_d = SHIFT;
          idx_d   = 2'd3;
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_gen_1011.sv
// Scoreboard bench for seq_gen_1011: expected bits queued at stimulus time,
// popped on every accepted transfer; frame timing checked per frame.
module tb_seq_gen_1011;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] reps = 4'd0;
  logic       out_ready = 1'b1;
  logic       out_bit, out_valid, busy, done;

  always #5 clk = ~clk;

  seq_gen_1011 #(.PATTERN(4'b1011), .GAP_LEN(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .reps      (reps),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  int         n_total = 0;
  int         n_bad = 0;
  bit         exp_q[$];
  int         xfer_cnt = 0;
  int         vld_cnt = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         det_cnt = 0;
  logic [3:0] sh = 4'd0;
  logic [3:0] pat_v = 4'b1011;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) vld_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (!out_valid) chk("idle_bit", int'(out_bit), 0);
    if (out_valid && out_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) chk("extra_bit", 1, 0);
      else chk("bit", int'(out_bit), int'(exp_q.pop_front()));
      sh = {sh[2:0], out_bit};
      if (sh == 4'b1011) det_cnt++;
    end
  end

  task automatic clear_counts();
    xfer_cnt = 0; vld_cnt = 0; busy_cnt = 0; done_cnt = 0; det_cnt = 0; sh = 4'd0;
  endtask

  task automatic push_frame(input int r);
    for (int k = 0; k < r; k++)
      for (int i = 3; i >= 0; i--) exp_q.push_back(pat_v[i]);
  endtask

  // exp_cycles: cycle (1 = first after accepting edge) on which done is high.
  task automatic run_frame(input int r, input int stall_at, input int stall_len,
                           input int start_at, input int exp_cycles, input bit skip_sync);
    int  c;
    int  done_c;
    bit  got;
    bit  stalled;
    exp_q.delete();
    clear_counts();
    push_frame(r);
    if (!skip_sync) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    reps = 4'(r);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    c = 1; got = 1'b0; done_c = 0;
    while (!got && c <= exp_cycles + 20) begin
      stalled = (stall_at != 0) && (c >= stall_at) && (c < stall_at + stall_len);
      out_ready = !stalled;
      start = (c == start_at);
      @(negedge clk);
      if (c == 1) chk("first_vld", int'(out_valid), int'(r != 0));
      if (stalled && exp_q.size() > 0) begin
        chk("stall_vld", int'(out_valid), 1);
        chk("stall_hold", int'(out_bit), int'(exp_q[0]));
      end
      if (done) begin
        got = 1'b1;
        done_c = c;
      end
      @(posedge clk);
      #1;
      c++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!got) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("frame_len", done_c, exp_cycles);
    chk("busy_cycles", busy_cnt, exp_cycles);
    chk("done_pulses", done_cnt, 1);
    chk("vld_cycles", vld_cnt, 4 * r + stall_len);
    chk("xfers", xfer_cnt, 4 * r);
    chk("bits_left", exp_q.size(), 0);
    chk("detections", det_cnt, r);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_bit", int'(out_bit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b1;

    run_frame(1, 0, 0, 0, 5, 1'b0);    // single frame, start on first edge after release
    run_frame(3, 0, 0, 0, 17, 1'b0);   // 1011 00 1011 00 1011
    run_frame(1, 2, 3, 0, 8, 1'b0);    // stall on bit index 2
    run_frame(0, 0, 0, 0, 1, 1'b0);    // zero reps
    run_frame(2, 0, 0, 3, 11, 1'b0);   // start pulsed during SHIFT
    run_frame(1, 0, 0, 5, 5, 1'b0);    // start coincident with done
    run_frame(15, 0, 0, 0, 89, 1'b0);  // full counter, no wrap

    // Abort mid-frame after the second bit has transferred.
    exp_q.delete();
    clear_counts();
    push_frame(2);
    @(posedge clk);
    #1;
    start = 1'b1;
    reps = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_vld", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_xfers", xfer_cnt, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    reset = 1'b1;
    run_frame(1, 0, 0, 0, 5, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_gen_1011.md
SEQ_GEN_1011 -- requirements
Module: seq_gen_1011

Interface
REQ-001 SHALL have parameter PATTERN, default 4'b1011: the 4-bit symbol transmitted MSB first.
REQ-002 SHALL have parameter GAP_LEN, default 2: idle cycles between repetitions, legal range 0..7.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 SHALL have port start, input, 1 bit: request to begin a frame; sampled only in IDLE.
REQ-006 SHALL have port reps, input, 4 bits: number of PATTERN repetitions in the frame; latched on accepted start.
REQ-007 SHALL have port out_ready, input, 1 bit: the downstream detector is ready to take out_bit this cycle.
REQ-008 SHALL have port out_bit, output, 1 bit: current serial bit.
REQ-009 SHALL have port out_valid, output, 1 bit: out_bit is a pattern bit this cycle.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress (any state other than IDLE).
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT, GAP and FIN.
REQ-013 In IDLE, start=1 at a rising edge SHALL latch reps.
  - reps!=0: go to SHIFT with bit index 3 and the repetition counter set to reps.
  - reps=0: go directly to FIN.
REQ-014 start SHALL be ignored in every state except IDLE; there is no queuing.
REQ-015 In SHIFT, out_valid=1 and out_bit=PATTERN[bit index], with the index running 3 down to 0.
REQ-016 The bit index SHALL advance only on a cycle with out_valid=1 and out_ready=1. With out_ready=0, out_bit and the index SHALL hold (stall of any length).
REQ-017 Transfer of bit index 0 SHALL decrement the repetition counter.
  - Counter reaches 0: next state FIN.
  - Otherwise, GAP_LEN>0: next state GAP.
  - Otherwise (GAP_LEN=0): stay in SHIFT with the index reset to 3, so repetitions are back-to-back.
REQ-018 In GAP, out_valid=0 and out_bit=0 for exactly GAP_LEN cycles, independent of out_ready; then go to SHIFT with the index reset to 3.
REQ-019 In FIN, done=1 for exactly one cycle, out_valid=0, then go to IDLE.
REQ-020 First-bit latency SHALL be one cycle: start accepted at edge N gives out_valid=1 in the cycle after edge N.
REQ-021 A frame with no stalls SHALL occupy 4*reps + GAP_LEN*(reps-1) SHIFT/GAP cycles plus one FIN cycle.
REQ-022 In IDLE and FIN: out_bit=0 and out_valid=0.
REQ-023 busy SHALL be 1 in SHIFT, GAP and FIN, and 0 in IDLE.
REQ-024 A start asserted in the same cycle that done=1 SHALL be ignored; the earliest new start is accepted on the following cycle (in IDLE).
REQ-025 The repetition counter SHALL be 4 bits with no wrap: reps=15 yields exactly 15 patterns.
REQ-026 All outputs SHALL be registered or decoded from registered state only; no combinational path from out_ready to out_valid.

Reset
REQ-027 reset=0 SHALL asynchronously force: state IDLE, bit index 3, repetition counter 0, out_bit=0, out_valid=0, busy=0, done=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no done pulse. After release the block SHALL be in IDLE and accept start on the first rising edge with reset=1.

Verification
REQ-029 Single frame: reps=1, out_ready=1, pulse start -> out_bit 1,0,1,1 with out_valid=1 on 4 consecutive cycles, done one cycle later, busy high for 5 cycles.
REQ-030 Repeat with gap: reps=3, GAP_LEN=2, out_ready=1 -> 1011 00 1011 00 1011 (valid low during gaps), then done; a looped-back seq_detect_1011 sees 3 detections.
REQ-031 Stall: reps=1, out_ready=0 for 3 cycles while the index points at bit 2 -> out_bit holds 0 with out_valid=1 for those 3 cycles, frame completes in 8 cycles.
REQ-032 Zero reps and start while busy: reps=0 -> out_valid never asserts, done on the next cycle. start pulsed during SHIFT -> no extra frame.
REQ-033 Reset mid-frame: reps=2, assert reset after the 2nd bit -> out_valid=0 and busy=0 immediately, no done pulse, new start after release gives a clean 1011.
